// File: rtl/graph_pkg.sv
// Shared types and constants for the graph-fetch memory responder.
// Used by graph_bram_dp and graph_mem_server.
package graph_pkg;

    localparam int WORD_W = 32;
    localparam logic [31:0] NULL_VERTEX = 32'd0;

    typedef enum logic {
        V_IDLE,
        V_CLEAR
    } vstate_t;

    // Number of 32-bit words the visited sweep must clear.
    function automatic int clear_words(input int visit_n);
        return visit_n / WORD_W;
    endfunction

endpackage

// File: rtl/graph_bram_dp.sv
// True dual-port read-first BRAM with a READ_LAT-deep output pipeline
// and a valid shift register per port. Out-of-range reads push zeros.
module graph_bram_dp #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          a_req,
    input  logic          a_rd,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic          a_valid,
    output logic [31:0]   a_data,
    input  logic          b_req,
    input  logic          b_rd,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [31:0]   b_wdata,
    output logic          b_valid,
    output logic [31:0]   b_data
);

    logic [31:0]         mem [DEPTH];
    logic [31:0]         a_pipe [READ_LAT];
    logic [31:0]         b_pipe [READ_LAT];
    logic [READ_LAT-1:0] a_vpipe;
    logic [READ_LAT-1:0] b_vpipe;

    // Array writes; port A is issued last so it wins a double write.
    always_ff @(posedge clk_in) begin
        if (b_we) mem[b_addr] <= b_wdata;
        if (a_we) mem[a_addr] <= a_wdata;
    end

    // Read-first data pipeline, left unreset so the array maps to BRAM.
    always_ff @(posedge clk_in) begin
        a_pipe[0] <= a_rd ? mem[a_addr] : '0;
        b_pipe[0] <= b_rd ? mem[b_addr] : '0;
        for (int i = 1; i < READ_LAT; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
        end
    end

    // Valid shift registers; reset drops every in-flight response.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_vpipe <= '0;
            b_vpipe <= '0;
        end else begin
            a_vpipe[0] <= a_req;
            b_vpipe[0] <= b_req;
            for (int i = 1; i < READ_LAT; i++) begin
                a_vpipe[i] <= a_vpipe[i-1];
                b_vpipe[i] <= b_vpipe[i-1];
            end
        end
    end

    assign a_valid = a_vpipe[READ_LAT-1];
    assign a_data  = a_pipe[READ_LAT-1];
    assign b_valid = b_vpipe[READ_LAT-1];
    assign b_data  = b_pipe[READ_LAT-1];

endmodule

// File: rtl/graph_mem_server.sv
// Graph memory responder: BRAM arbitration, index skid, visited bitmap.
// Optional macro GRAPH_MEM_TEST_AND_SET_EN makes lookups test-and-set.
module graph_mem_server
    import graph_pkg::*;
#(
    parameter int DIM      = 2,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2,
    parameter int VISIT_N  = 256
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        mem_valid_in,
    input  logic [31:0] mem_req_in,
    output logic        mem_valid_out,
    output logic [31:0] mem_data_out,
    input  logic        mem_valid_in2,
    input  logic [31:0] mem_req_in2,
    output logic        mem_valid_out2,
    output logic [31:0] mem_data_out2,
    input  logic        mem_idx_valid_in,
    input  logic [31:0] mem_idx_in,
    output logic        mem_idx_valid_out,
    output logic [31:0] mem_idx_out,
    input  logic        visited_req_valid_in,
    input  logic [31:0] visited_req_in,
    output logic        visited_val_returned_valid_out,
    output logic        visited_val_returned_out,
    input  logic        wr_en_in,
    input  logic [31:0] wr_addr_in,
    input  logic [31:0] wr_data_in,
    input  logic        clear_in,
    output logic        busy_out,
    output logic        err_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(VISIT_N);
    localparam int NW = clear_words(VISIT_N);
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    if (DIM < 1 || READ_LAT < 1 || (VISIT_N % WORD_W) != 0)
    begin : g_bad_cfg
        $error("graph_mem_server: illegal parameter set");
    end

    // ---- port A: loader write vs. position read ----
    logic        bmp_wr;
    logic        a_wr;
    logic        a_hit;
    logic        a_req;
    logic        a_rd;
    logic        a_we;
    logic [AW-1:0] a_addr;
    logic        a_valid;
    logic [31:0] a_data;

`ifdef GRAPH_MEM_TEST_AND_SET_EN
    assign bmp_wr = 1'b0;
`else
    assign bmp_wr = wr_en_in & wr_addr_in[31];
`endif

    assign a_wr   = wr_en_in & ~bmp_wr;
    assign a_hit  = mem_valid_in & a_wr;
    assign a_req  = mem_valid_in & ~a_wr;
    assign a_rd   = a_req & (mem_req_in < 32'(DEPTH));
    assign a_we   = a_wr & (wr_addr_in < 32'(DEPTH));
    assign a_addr = a_wr ? wr_addr_in[AW-1:0]
                         : mem_req_in[AW-1:0];

    // ---- port B: neighbor read, then skid, then fresh index ----
    logic        skid_v;
    logic [31:0] skid_addr;
    logic        b_req;
    logic        b_sel;
    logic        b_rd;
    logic [31:0] b_addr;
    logic        idx_park;
    logic        idx_drop;
    logic        b_valid;
    logic [31:0] b_data;
    logic [READ_LAT-1:0] bsel_pipe;

    // Port B issue select: neighbor reads always own the port.
    always_comb begin
        b_req  = mem_valid_in2 | skid_v | mem_idx_valid_in;
        b_sel  = ~mem_valid_in2 & b_req;
        b_addr = mem_idx_in;
        if (mem_valid_in2)
            b_addr = mem_req_in2;
        else if (skid_v)
            b_addr = skid_addr;
        b_rd     = b_req & (b_addr < 32'(DEPTH));
        idx_drop = mem_idx_valid_in & skid_v;
        idx_park = mem_idx_valid_in & ~skid_v & mem_valid_in2;
    end

    // Skid entry fills on a collision and drains on a free port cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            skid_v    <= 1'b0;
            skid_addr <= '0;
        end else if (idx_park) begin
            skid_v    <= 1'b1;
            skid_addr <= mem_idx_in;
        end else if (skid_v && !mem_valid_in2) begin
            skid_v    <= 1'b0;
        end
    end

    // Tags each port-B response as neighbor (0) or row index (1).
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bsel_pipe <= '0;
        end else begin
            bsel_pipe[0] <= b_sel;
            for (int i = 1; i < READ_LAT; i++)
                bsel_pipe[i] <= bsel_pipe[i-1];
        end
    end

    graph_bram_dp #(
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT),
        .AW       (AW)
    ) u_bram (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .a_req    (a_req),
        .a_rd     (a_rd),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (wr_data_in),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .b_req    (b_req),
        .b_rd     (b_rd),
        .b_we     (1'b0),
        .b_addr   (b_addr[AW-1:0]),
        .b_wdata  (32'd0),
        .b_valid  (b_valid),
        .b_data   (b_data)
    );

    assign mem_valid_out     = a_valid;
    assign mem_data_out      = a_valid ? a_data : NULL_VERTEX;
    assign mem_valid_out2    = b_valid & ~bsel_pipe[READ_LAT-1];
    assign mem_data_out2     = mem_valid_out2 ? b_data : NULL_VERTEX;
    assign mem_idx_valid_out = b_valid & bsel_pipe[READ_LAT-1];
    assign mem_idx_out       = mem_idx_valid_out ? b_data : NULL_VERTEX;

    // ---- visited bitmap and clear sweep ----
    vstate_t        state;
    vstate_t        state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [VISIT_N-1:0] bitmap;
    logic           hold_v;
    logic           hold_v_nxt;
    logic [31:0]    hold_id;
    logic [31:0]    hold_id_nxt;
    logic           hold_drop;
    logic           ans_v;
    logic [31:0]    ans_id;
    logic           ans_in;
    logic           ans_bit;
    logic           vis_v;
    logic           vis_bit;

    // FSM state and sweep word counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= V_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a clear pulse (re)starts the sweep at word 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            V_IDLE: begin
                if (clear_in) begin
                    state_nxt = V_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            V_CLEAR: begin
                if (clear_in) begin
                    cnt_nxt = '0;
                end else if (cnt == CW'(NW - 1)) begin
                    state_nxt = V_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = V_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy_out = (state == V_CLEAR);

    // Lookup routing: park during a sweep, answer the parked one first.
    always_comb begin
        ans_v       = 1'b0;
        ans_id      = visited_req_in;
        hold_v_nxt  = hold_v;
        hold_id_nxt = hold_id;
        hold_drop   = 1'b0;
        if (state == V_CLEAR) begin
            if (visited_req_valid_in) begin
                if (hold_v) begin
                    hold_drop = 1'b1;
                end else begin
                    hold_v_nxt  = 1'b1;
                    hold_id_nxt = visited_req_in;
                end
            end
        end else if (hold_v) begin
            ans_v       = 1'b1;
            ans_id      = hold_id;
            hold_v_nxt  = visited_req_valid_in;
            hold_id_nxt = visited_req_in;
        end else begin
            ans_v = visited_req_valid_in;
        end
    end

    assign ans_in  = ans_id < 32'(VISIT_N);
    assign ans_bit = ans_in ? bitmap[ans_id[IW-1:0]] : 1'b1;

    // Parked lookup register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hold_v  <= 1'b0;
            hold_id <= '0;
        end else begin
            hold_v  <= hold_v_nxt;
            hold_id <= hold_id_nxt;
        end
    end

    // Bitmap update; the sweep is applied last so a clear always wins.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bitmap <= '0;
        end else begin
`ifdef GRAPH_MEM_TEST_AND_SET_EN
            if (ans_v && ans_in)
                bitmap[ans_id[IW-1:0]] <= 1'b1;
`else
            if (bmp_wr && wr_addr_in[30:0] < 31'(VISIT_N))
                bitmap[wr_addr_in[IW-1:0]] <= wr_data_in[0];
`endif
            if (state == V_CLEAR)
                bitmap[int'(cnt)*WORD_W +: WORD_W] <= '0;
        end
    end

    // Lookup response register, one cycle after the answer decision.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vis_v   <= 1'b0;
            vis_bit <= 1'b0;
        end else begin
            vis_v   <= ans_v;
            vis_bit <= ans_v & ans_bit;
        end
    end

    assign visited_val_returned_valid_out = vis_v;
    assign visited_val_returned_out       = vis_bit;

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            err_out <= 1'b0;
        else if (a_hit || idx_drop || hold_drop)
            err_out <= 1'b1;
    end

endmodule

// File: tb/tb_graph_mem_server.sv
// Directed bench for graph_mem_server with a response scoreboard.
// Works with or without GRAPH_MEM_TEST_AND_SET_EN.
module tb_graph_mem_server;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        mem_valid_in;
    logic [31:0] mem_req_in;
    logic        mem_valid_out;
    logic [31:0] mem_data_out;
    logic        mem_valid_in2;
    logic [31:0] mem_req_in2;
    logic        mem_valid_out2;
    logic [31:0] mem_data_out2;
    logic        mem_idx_valid_in;
    logic [31:0] mem_idx_in;
    logic        mem_idx_valid_out;
    logic [31:0] mem_idx_out;
    logic        visited_req_valid_in;
    logic [31:0] visited_req_in;
    logic        vis_v;
    logic        vis_val;
    logic        wr_en_in;
    logic [31:0] wr_addr_in;
    logic [31:0] wr_data_in;
    logic        clear_in;
    logic        busy_out;
    logic        err_out;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qi[$];
    exp_t qv[$];

    int cyc    = 0;
    int checks = 0;
    int fails  = 0;

    graph_mem_server dut (
        .clk_in                         (clk_in),
        .rst_n_in                       (rst_n_in),
        .mem_valid_in                   (mem_valid_in),
        .mem_req_in                     (mem_req_in),
        .mem_valid_out                  (mem_valid_out),
        .mem_data_out                   (mem_data_out),
        .mem_valid_in2                  (mem_valid_in2),
        .mem_req_in2                    (mem_req_in2),
        .mem_valid_out2                 (mem_valid_out2),
        .mem_data_out2                  (mem_data_out2),
        .mem_idx_valid_in               (mem_idx_valid_in),
        .mem_idx_in                     (mem_idx_in),
        .mem_idx_valid_out              (mem_idx_valid_out),
        .mem_idx_out                    (mem_idx_out),
        .visited_req_valid_in           (visited_req_valid_in),
        .visited_req_in                 (visited_req_in),
        .visited_val_returned_valid_out (vis_v),
        .visited_val_returned_out       (vis_val),
        .wr_en_in                       (wr_en_in),
        .wr_addr_in                     (wr_addr_in),
        .wr_data_in                     (wr_data_in),
        .clear_in                       (clear_in),
        .busy_out                       (busy_out),
        .err_out                        (err_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [31:0] a,
                      input logic [31:0] d);
        wr_en_in   = 1'b1;
        wr_addr_in = a;
        wr_data_in = d;
        step();
        wr_en_in   = 1'b0;
    endtask

    task automatic rd_a(input logic [31:0] a,
                        input logic [31:0] e);
        mem_valid_in = 1'b1;
        mem_req_in   = a;
        qa.push_back('{e, cyc + 2});
        step();
        mem_valid_in = 1'b0;
    endtask

    task automatic look(input logic [31:0] id,
                        input logic e);
        visited_req_valid_in = 1'b1;
        visited_req_in       = id;
        qv.push_back('{32'(e), cyc + 1});
        step();
        visited_req_valid_in = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_va"}, 32'(mem_valid_out), 0);
        check({tag, "_da"}, mem_data_out, 0);
        check({tag, "_vb"}, 32'(mem_valid_out2), 0);
        check({tag, "_db"}, mem_data_out2, 0);
        check({tag, "_vi"}, 32'(mem_idx_valid_out), 0);
        check({tag, "_di"}, mem_idx_out, 0);
        check({tag, "_vv"}, 32'(vis_v), 0);
        check({tag, "_vd"}, 32'(vis_val), 0);
        check({tag, "_busy"}, 32'(busy_out), 0);
        check({tag, "_err"}, 32'(err_out), 0);
    endtask

    // Scoreboard: every response must match the head of its queue.
    always @(negedge clk_in) begin
        exp_t e;
        if (mem_valid_out) begin
            if (qa.size() == 0) begin
                check("a_spurious", 32'(mem_valid_out), 0);
            end else begin
                e = qa.pop_front();
                check("a_data", mem_data_out, e.d);
                check("a_cycle", cyc, e.c);
            end
        end
        if (mem_valid_out2) begin
            if (qb.size() == 0) begin
                check("b_spurious", 32'(mem_valid_out2), 0);
            end else begin
                e = qb.pop_front();
                check("b_data", mem_data_out2, e.d);
                check("b_cycle", cyc, e.c);
            end
        end
        if (mem_idx_valid_out) begin
            if (qi.size() == 0) begin
                check("i_spurious", 32'(mem_idx_valid_out), 0);
            end else begin
                e = qi.pop_front();
                check("i_data", mem_idx_out, e.d);
                check("i_cycle", cyc, e.c);
            end
        end
        if (vis_v) begin
            if (qv.size() == 0) begin
                check("v_spurious", 32'(vis_v), 0);
            end else begin
                e = qv.pop_front();
                check("v_data", 32'(vis_val), e.d);
                check("v_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        rst_n_in             = 1'b0;
        mem_valid_in         = 1'b0;
        mem_req_in           = '0;
        mem_valid_in2        = 1'b0;
        mem_req_in2          = '0;
        mem_idx_valid_in     = 1'b0;
        mem_idx_in           = '0;
        visited_req_valid_in = 1'b0;
        visited_req_in       = '0;
        wr_en_in             = 1'b0;
        wr_addr_in           = '0;
        wr_data_in           = '0;
        clear_in             = 1'b0;

        repeat (3) step();
        all_zero("reset");
        rst_n_in = 1'b1;
        step();

        // load image
        wr(5, 9);
        wr(10, 7);
        wr(4, 12);
        wr(3, 33);
        wr(2, 44);
        step();

        // A and B in the same cycle
        mem_valid_in  = 1'b1;
        mem_req_in    = 5;
        mem_valid_in2 = 1'b1;
        mem_req_in2   = 10;
        qa.push_back('{32'd9, cyc + 2});
        qb.push_back('{32'd7, cyc + 2});
        step();
        mem_valid_in  = 1'b0;
        mem_valid_in2 = 1'b0;
        repeat (3) step();

        // back-to-back A reads
        rd_a(5, 9);
        rd_a(10, 7);
        rd_a(4, 12);
        repeat (3) step();

        // write then read the new word
        wr(20, 32'h55);
        rd_a(20, 32'h55);
        repeat (3) step();

        // B/idx collision goes to skid
        mem_valid_in2    = 1'b1;
        mem_req_in2      = 3;
        mem_idx_valid_in = 1'b1;
        mem_idx_in       = 4;
        qb.push_back('{32'd33, cyc + 2});
        qi.push_back('{32'd12, cyc + 3});
        step();
        mem_valid_in2 = 1'b0;
        check("skid_err0", 32'(err_out), 0);
        mem_idx_in = 5;
        step();
        mem_idx_valid_in = 1'b0;
        check("skid_err1", 32'(err_out), 1);
        repeat (4) step();

        // out-of-range addresses return the sentinel
        rd_a(2000, 0);
        mem_valid_in2    = 1'b1;
        mem_req_in2      = 5000;
        mem_idx_valid_in = 1'b1;
        mem_idx_in       = 3000;
        qb.push_back('{32'd0, cyc + 2});
        qi.push_back('{32'd0, cyc + 3});
        step();
        mem_valid_in2    = 1'b0;
        mem_idx_valid_in = 1'b0;
        repeat (4) step();

        // visited lookups
`ifdef GRAPH_MEM_TEST_AND_SET_EN
        look(7, 1'b0);
        look(7, 1'b1);
        look(300, 1'b1);
        look(8, 1'b0);
`else
        wr(32'h8000_0007, 1);
        look(7, 1'b1);
        look(8, 1'b0);
        look(300, 1'b1);
        wr(32'h8000_0008, 1);
        look(8, 1'b1);
`endif
        repeat (2) step();

        // clear sweep with a lookup parked at sweep cycle 3
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("busy_%0d", k),
                  32'(busy_out), (k < 8) ? 32'd1 : 32'd0);
            if (k == 3) begin
                visited_req_valid_in = 1'b1;
                visited_req_in       = 7;
                qv.push_back('{32'd0, cyc + 6});
            end
            step();
            visited_req_valid_in = 1'b0;
        end
        step();
        look(8, 1'b0);
        step();

        // reset one cycle after an A read: nothing may emerge
        mem_valid_in = 1'b1;
        mem_req_in   = 5;
        step();
        mem_valid_in = 1'b0;
        rst_n_in     = 1'b0;
        #1;
        all_zero("midrst");
        step();
        step();
        rst_n_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("post_rst_va", 32'(mem_valid_out), 0);
            step();
        end

        // loader write beats a same-cycle A read
        check("coll_err0", 32'(err_out), 0);
        wr_en_in     = 1'b1;
        wr_addr_in   = 30;
        wr_data_in   = 32'h77;
        mem_valid_in = 1'b1;
        mem_req_in   = 5;
        step();
        wr_en_in     = 1'b0;
        mem_valid_in = 1'b0;
        check("coll_err1", 32'(err_out), 1);
        rd_a(30, 32'h77);

        repeat (8) step();
        check("qa_empty", qa.size(), 0);
        check("qb_empty", qb.size(), 0);
        check("qi_empty", qi.size(), 0);
        check("qv_empty", qv.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/graph_mem_server.md
# graph_mem_server

Responder side of the graph-fetch memory protocol: answers position/vertex-id reads, neighbor-list reads, row-index reads and visited-bit lookups issued by the graph fetch unit. Holds the graph image in a true dual-port BRAM and the visited set in a register bitmap with a bulk-clear sweep. Sits between the host loader and one fetch unit, with no ready signals toward the fetch unit, so every accepted request is answered at fixed latency or flagged.

## Interface
- DIM, 2: position dimensions per vertex record (informational; fixes the record stride DIM+1 used by the tests).
- DEPTH, 1024: BRAM words (32-bit).
- READ_LAT, 2: BRAM read latency in cycles, ≥1.
- VISIT_N, 256: vertex ids covered by the visited bitmap; a multiple of 32.
- clk_in  input  1  the single clock.
- rst_n_in  input  1  reset; asynchronous, active-low.
- mem_valid_in / mem_req_in  input  1/32  port A read: vertex id or position word address.
- mem_valid_out / mem_data_out  output  1/32  port A response.
- mem_valid_in2 / mem_req_in2  input  1/32  port B read: neighbor list word.
- mem_valid_out2 / mem_data_out2  output  1/32  port B response.
- mem_idx_valid_in / mem_idx_in  input  1/32  row-index read; shares port B.
- mem_idx_valid_out / mem_idx_out  output  1/32  row-index response.
- visited_req_valid_in / visited_req_in  input  1/32  visited lookup by vertex id.
- visited_val_returned_valid_out / visited_val_returned_out  output  1/1  lookup response.
- wr_en_in / wr_addr_in / wr_data_in  input  1/32/32  loader write; uses port A.
- clear_in  input  1  pulse: clear the whole visited bitmap.
- busy_out  output  1  clear sweep in progress.
- err_out  output  1  sticky: a request was dropped.

## Operation
- Reset: all outputs 0. Bitmap all 0. Valid pipelines empty. State V_IDLE. Skid register empty.
- Port A: a read returns BRAM[addr]. A write at the same cycle wins, the read is dropped, and err_out is set. Write-then-read to the same address returns the new data (read-first BRAM, later cycle).
- Port B: a mem_valid_in2 read always issues. A row-index read that collides with it goes into a one-entry skid register and issues on the next cycle with no port-B request. If the skid register is already full, the new index request is dropped and err_out is set.
- Address ≥ DEPTH on any port: no BRAM access. The response is 0 (end-of-list sentinel) at normal latency.
- Visited lookup: returns bitmap[id]. An id ≥ VISIT_N returns 1, so out-of-range neighbors are never enqueued.
- Visited FSM:
  - V_IDLE → V_CLEAR on clear_in.
  - V_CLEAR clears 32 bits per cycle for VISIT_N/32 cycles, then returns to V_IDLE.
  - busy_out = (state == V_CLEAR).
  - A lookup arriving in V_CLEAR is held in a one-entry register and answered the cycle after V_IDLE is re-entered; it returns 0. A second lookup arriving while one is held is dropped and sets err_out.
  - clear_in while in V_CLEAR restarts the sweep at word 0.
- err_out clears only on reset.

## Timing
- BRAM responses: data/valid appear exactly READ_LAT cycles after the request cycle, or after the issue cycle for skid-delayed index reads (READ_LAT+1 total). Back-to-back requests get back-to-back responses in order.
- Visited response: 1 cycle after the request in V_IDLE.
- Reset asserted mid-operation: all in-flight valids are discarded immediately. No response emerges after rst_n_in deasserts.

## Configuration
- GRAPH_MEM_TEST_AND_SET_EN defined:
  - A visited lookup also sets bitmap[id] in the same cycle (atomic test-and-set). The returned value is the old bit.
  - A lookup and a clear sweep touching the same word in one cycle: the clear wins.
- Undefined: lookups are read-only. The bitmap is set only by loader writes with wr_addr_in[31] = 1: bit wr_addr_in[30:0] := wr_data_in[0]. BRAM is not written in that case.

## Structure
- graph_pkg:
  - typedef enum {V_IDLE, V_CLEAR} vstate_t.
  - Constant WORD_W = 32.
  - Constant NULL_VERTEX = 0.
  - Function for clear-word count.
- Sub-module graph_bram_dp: true dual-port, read-first, READ_LAT-deep output pipeline, valid shift register per port. graph_mem_server holds the arbitration, skid register, bitmap and FSM.

## Test plan
- Load BRAM[5]=9, BRAM[10]=7; read A@5 and B@10 in the same cycle → mem_data_out=9, mem_data_out2=7, both 2 cycles later.
- B@3 and idx@4 in the same cycle (BRAM[4]=12) → mem_data_out2 at +2; mem_idx_out=12 at +3; err_out=0. A third idx request colliding while the skid register is full → err_out=1.
- Read A@2000 (≥ DEPTH) → mem_data_out=0, mem_valid_out=1 at +2.
- With TEST_AND_SET_EN: lookup id 7 twice → returns 0 then 1. Lookup id 300 → returns 1.
- Set id 7, pulse clear_in, look up id 7 at sweep cycle 3 → busy_out high 8 cycles; response 0 the cycle after busy_out falls.
- Assert rst_n_in one cycle after an A read → no mem_valid_out ever appears. All outputs 0.
